imm_encoder: RTL
================

# imm_encoder

Constant-to-immediate encoder: the inverse of the immediate extender. Takes a 32-bit constant (or a branch byte offset) and emits the shortest stream of (16-bit immediate, EOp) beats that the extender reconstructs back to the same value. It sits in the assembler/test-vector path ahead of instruction packing. Single beats cover sign-extend, zero-extend, upper-load and branch forms. Any other constant becomes a two-beat upper-load + OR pair.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state on a clk edge where it is high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_value  input  32  constant to encode (branch: byte offset)
- in_branch  input  1  1 = encode as branch offset (EOp 11 only)
- out_valid  output  1  beat valid
- out_ready  input  1  consumer accepts beat
- out_imm  output  16  immediate field
- out_eop  output  2  extender op: 00 sign-ext, 01 zero-ext, 10 upper (imm<<16), 11 sign-ext then <<2
- out_last  output  1  final beat of current request
- out_err  output  1  request not encodable (branch only)

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - ONE: single beat held.
  - HI: first of a two-beat pair held.
  - LO: second of a two-beat pair held.
- Accept occurs when in_valid && in_ready. in_value and in_branch are captured in full at accept.
- Classification at accept, non-branch, first match wins:
  1. in_value[31:15] all equal: ONE, imm=in_value[15:0], eop=00.
  2. in_value[31:16]==0: ONE, imm=in_value[15:0], eop=01.
  3. in_value[15:0]==0: ONE, imm=in_value[31:16], eop=10.
  4. Otherwise: HI, imm=in_value[31:16], eop=10, last=0. Then LO, imm=in_value[15:0], eop=01, last=1.
- Branch (in_branch=1):
  - Encodable when in_value[1:0]==0 and in_value[31:17] all equal. Result is ONE, imm=in_value[17:2], eop=11, err=0.
  - Otherwise ONE, imm=0, eop=11, err=1.
- out_err is 0 for every non-branch beat.
- out_last=1 in ONE and LO, 0 in HI.
- Transitions:
  - ONE→IDLE and LO→IDLE on out_valid && out_ready.
  - HI→LO on out_valid && out_ready.
  - No transition while out_ready=0.
- Correctness invariant: sign-ext, zero-ext, upper and shifted-sign-ext of emitted beats reproduce in_value exactly. For pairs, the result is (upper-beat value) OR (zero-ext lower beat).

## Timing
- Reset values:
  - state=IDLE
  - out_valid=0, out_imm=16'h0000, out_eop=2'b00, out_last=0, out_err=0
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
- Latency: first beat is valid in the cycle after accept, from a registered output. No combinational path from in_* to out_*.
- out_imm, out_eop, out_last and out_err are held stable while out_valid=1 and out_ready=0.
- in_ready is combinational from state only (state==IDLE). It does not depend on out_ready.
- Throughput:
  - Single-beat request: 2 cycles (accept, then beat).
  - Pair: 3 cycles, with out_ready held high.
  - IDLE is re-entered on the edge that consumes the last beat. The next accept can happen in the following cycle.
- in_valid while not IDLE is ignored; the requester must hold the request.
- Reset asserted mid-request, including in HI with the LO beat pending:
  - The request is dropped and the LO beat is never emitted.
  - All outputs return to their reset values on that edge.

## Test plan
- Reset → out_valid=0, out_imm=0, out_eop=00, out_last=0, out_err=0; in_ready=1 the cycle after deassert.
- Non-branch single beats, one per request:
  - in_value=32'hFFFF_8001 → one beat: imm=16'h8001, eop=00, last=1.
  - in_value=32'h0000_8000 → imm=16'h8000, eop=01.
  - in_value=32'h1234_0000 → imm=16'h1234, eop=10.
  - in_value=32'h0000_0000 → imm=0, eop=00.
- Two-beat pair: in_value=32'h1234_5678 with out_ready=1 → beat 1: imm=16'h1234, eop=10, last=0; beat 2: imm=16'h5678, eop=01, last=1; in_ready=1 in the cycle after beat 2.
- Branch offsets, in_branch=1:
  - in_value=32'hFFFF_FFFC → imm=16'hFFFF, eop=11, err=0.
  - in_value=32'h0001_FFFC → imm=16'h7FFF, err=0.
  - in_value=32'h0002_0000 → err=1, imm=0.
  - in_value=32'h0000_0006 → err=1.
- Backpressure: pair 32'hDEAD_BEEF, out_ready=0 for 3 cycles in HI → beat stays imm=16'hDEAD, eop=10, with in_ready=0 throughout; then out_ready=1 → LO beat imm=16'hBEEF, eop=01.
- Reset mid-pair: assert reset in HI of 32'hDEAD_BEEF → next cycle all outputs are at reset values; no 16'hBEEF beat appears afterwards.

Source files
------------

// File: rtl/imm_encoder.sv
// Constant-to-immediate encoder: turns a 32-bit constant or branch byte offset
// into the shortest (imm, eop) beat stream the immediate extender rebuilds exactly.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic        in_branch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONE  = 2'b01,
        HI   = 2'b10,
        LO   = 2'b11
    } state_t;

    localparam logic [1:0] EOP_SEXT  = 2'b00;
    localparam logic [1:0] EOP_ZEXT  = 2'b01;
    localparam logic [1:0] EOP_UPPER = 2'b10;
    localparam logic [1:0] EOP_BR    = 2'b11;

    state_t      r_state;
    logic        r_out_valid;
    logic [15:0] r_out_imm;
    logic [1:0]  r_out_eop;
    logic        r_out_last;
    logic        r_out_err;
    logic [15:0] r_lo_imm;

    state_t      w_next_state;
    logic        w_next_valid;
    logic [15:0] w_next_imm;
    logic [1:0]  w_next_eop;
    logic        w_next_last;
    logic        w_next_err;
    logic [15:0] w_next_lo_imm;

    logic        w_accept;
    logic        w_sext_ok;
    logic        w_zext_ok;
    logic        w_upper_ok;
    logic        w_branch_ok;

    assign in_ready  = (r_state == IDLE) && !reset;
    assign w_accept  = in_valid && in_ready;

    assign w_sext_ok   = (&in_value[31:15]) || (~|in_value[31:15]);
    assign w_zext_ok   = ~|in_value[31:16];
    assign w_upper_ok  = ~|in_value[15:0];
    // Branch offsets must be word aligned and fit an 18-bit signed byte offset.
    assign w_branch_ok = (in_value[1:0] == 2'b00) &&
                         ((&in_value[31:17]) || (~|in_value[31:17]));

    always_comb begin
        w_next_state  = r_state;
        w_next_valid  = r_out_valid;
        w_next_imm    = r_out_imm;
        w_next_eop    = r_out_eop;
        w_next_last   = r_out_last;
        w_next_err    = r_out_err;
        w_next_lo_imm = r_lo_imm;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_valid = 1'b1;
                    w_next_last  = 1'b1;
                    w_next_err   = 1'b0;
                    w_next_state = ONE;
                    if (in_branch) begin
                        w_next_eop = EOP_BR;
                        if (w_branch_ok) begin
                            w_next_imm = in_value[17:2];
                        end else begin
                            w_next_imm = 16'h0000;
                            w_next_err = 1'b1;
                        end
                    end else if (w_sext_ok) begin
                        w_next_imm = in_value[15:0];
                        w_next_eop = EOP_SEXT;
                    end else if (w_zext_ok) begin
                        w_next_imm = in_value[15:0];
                        w_next_eop = EOP_ZEXT;
                    end else if (w_upper_ok) begin
                        w_next_imm = in_value[31:16];
                        w_next_eop = EOP_UPPER;
                    end else begin
                        w_next_imm    = in_value[31:16];
                        w_next_eop    = EOP_UPPER;
                        w_next_last   = 1'b0;
                        w_next_lo_imm = in_value[15:0];
                        w_next_state  = HI;
                    end
                end else begin
                    w_next_valid = 1'b0;
                end
            end
            ONE, LO: begin
                if (out_ready) begin
                    w_next_valid = 1'b0;
                    w_next_state = IDLE;
                end else begin
                    w_next_valid = 1'b1;
                end
            end
            HI: begin
                if (out_ready) begin
                    w_next_imm   = r_lo_imm;
                    w_next_eop   = EOP_ZEXT;
                    w_next_last  = 1'b1;
                    w_next_state = LO;
                end else begin
                    w_next_valid = 1'b1;
                end
            end
            default: begin
                w_next_valid = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // State and registered beat outputs; reset drops any pending low half.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_imm   <= 16'h0000;
            r_out_eop   <= 2'b00;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
            r_lo_imm    <= 16'h0000;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= w_next_valid;
            r_out_imm   <= w_next_imm;
            r_out_eop   <= w_next_eop;
            r_out_last  <= w_next_last;
            r_out_err   <= w_next_err;
            r_lo_imm    <= w_next_lo_imm;
        end
    end

    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;
    assign out_eop   = r_out_eop;
    assign out_last  = r_out_last;
    assign out_err   = r_out_err;

endmodule
